// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous FIFO into a valid/ready stream through a small skid buffer
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = 16,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_drain_en,
    input  logic                  i_fifo_empty,
    input  logic [FIFO_WIDTH-1:0] i_fifo_data_out,
    input  logic                  i_fifo_underflow,
    output logic                  o_fifo_rd_en,
    output logic                  o_m_valid,
    output logic [FIFO_WIDTH-1:0] o_m_data,
    input  logic                  i_m_ready,
    output logic [CNT_WIDTH-1:0]  o_words_out,
    output logic                  o_err_underflow
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_inflight;
    logic                  r_en;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_words;
    logic                  w_cap;
    logic                  w_pop;
    logic [CW:0]           w_occ;
    logic [PW-1:0]         w_wr_nxt;
    logic [PW-1:0]         w_rd_nxt;

    // Occupancy counts the read in flight so the buffer can never be overrun; the
    // current pop is deliberately not credited, keeping m_ready off the rd_en path.
    assign w_occ        = {1'b0, r_count} + (CW+1)'(r_inflight);
    assign o_fifo_rd_en = r_en & i_drain_en & ~i_fifo_empty & (w_occ < (CW+1)'(BUF_DEPTH));
    assign w_cap        = r_inflight & ~i_fifo_underflow;
    assign o_m_valid    = (r_count != '0);
    assign w_pop        = o_m_valid & i_m_ready;
    assign o_m_data     = o_m_valid ? r_buf[r_rd_ptr] : '0;
    assign w_wr_nxt     = (r_wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_nxt     = (r_rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
    assign o_words_out  = r_words;
    assign o_err_underflow = r_err;

    // Skid buffer storage; contents are only meaningful below r_count so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_cap) r_buf[r_wr_ptr] <= i_fifo_data_out;
    end

    // Control state: read tracking, pointers, occupancy, delivered count and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en       <= 1'b0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_words    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_en       <= 1'b1;
            r_inflight <= o_fifo_rd_en;
            r_wr_ptr   <= w_cap ? w_wr_nxt : r_wr_ptr;
            r_rd_ptr   <= w_pop ? w_rd_nxt : r_rd_ptr;
            r_count    <= r_count + CW'(w_cap) - CW'(w_pop);
            r_words    <= r_words + CNT_WIDTH'(w_pop);
            r_err      <= r_err | (r_inflight & i_fifo_underflow);
        end
    end
endmodule
